ysyx_24080006_if_stage: RTL and testbench

Instruction-fetch stage of the multi-cycle core; one instruction in flight at a time. Holds the architectural PC and fetches each instruction over an AXI4 read-only master port, then hands it to the decode stage with a valid/ready handshake. It then waits for the execute stage's completion handshake, which carries the redirect target, and uses it to compute the next PC.

---
 rtl/ysyx_24080006_if_stage.sv | 113 +++++++++++
 tb/tb_ysyx_24080006_if_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_if_stage.sv
// ysyx_24080006_if_stage: single-issue instruction fetch over an AXI4 read port, with decode/execute handshakes
module ysyx_24080006_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  output logic [2:0]  ifu_arsize,
  output logic [7:0]  ifu_arlen,
  output logic [1:0]  ifu_arburst,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  input  logic        ifu_rlast,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  output logic        ifu2idu_valid,
  input  logic        idu2ifu_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic        ifu2exu_ready,
  input  logic        exu2ifu_valid,
  input  logic [31:0] exu2ifu_dnpc,
  input  logic        exu2ifu_jump,
  input  logic        exu2ifu_branch
);
  typedef enum logic [2:0] {BOOT, AR, R, ID, EX} state_t;
  state_t r_state, w_state_n;
  logic r_arvalid, w_arvalid_n;
  logic r_rready, w_rready_n;
  logic r_idu_valid, w_idu_valid_n;
  logic r_exu_ready, w_exu_ready_n;
  logic r_err, w_err_n;
  logic [31:0] r_inst, w_inst_n;
  logic [31:0] r_pc, w_pc_n;
  logic w_unused;
  // single beat only, so rlast carries no information
  assign w_unused = ifu_rlast;
  assign ifu_araddr = {r_pc[31:2], 2'b00};
  assign ifu_arvalid = r_arvalid;
  assign ifu_arsize = 3'b010;
  assign ifu_arlen = 8'd0;
  assign ifu_arburst = 2'b01;
  assign ifu_rready = r_rready;
  assign ifu2idu_valid = r_idu_valid;
  assign inst = r_inst;
  assign pc = r_pc;
  assign fetch_err = r_err;
  assign ifu2exu_ready = r_exu_ready;
  always_comb begin
    w_state_n = r_state;
    w_arvalid_n = r_arvalid;
    w_rready_n = r_rready;
    w_idu_valid_n = r_idu_valid;
    w_exu_ready_n = r_exu_ready;
    w_err_n = r_err;
    w_inst_n = r_inst;
    w_pc_n = r_pc;
    case (r_state)
      BOOT: begin
        w_state_n = AR;
        w_arvalid_n = 1'b1;
      end
      AR: if (r_arvalid && ifu_arready) begin
        w_state_n = R;
        w_arvalid_n = 1'b0;
        w_rready_n = 1'b1;
      end
      R: if (r_rready && ifu_rvalid) begin
        w_state_n = ID;
        w_rready_n = 1'b0;
        w_inst_n = ifu_rdata;
        w_err_n = (ifu_rresp != 2'b00) || (r_pc[1:0] != 2'b00);
        w_idu_valid_n = 1'b1;
      end
      ID: if (r_idu_valid && idu2ifu_ready) begin
        w_state_n = EX;
        w_idu_valid_n = 1'b0;
        w_exu_ready_n = 1'b1;
      end
      EX: if (r_exu_ready && exu2ifu_valid) begin
        w_state_n = AR;
        w_exu_ready_n = 1'b0;
        w_arvalid_n = 1'b1;
        w_pc_n = (exu2ifu_jump || exu2ifu_branch) ? exu2ifu_dnpc : r_pc + 32'd4;
      end
      default: w_state_n = BOOT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= BOOT;
      r_arvalid <= 1'b0;
      r_rready <= 1'b0;
      r_idu_valid <= 1'b0;
      r_exu_ready <= 1'b0;
      r_err <= 1'b0;
      r_inst <= 32'd0;
      r_pc <= RESET_PC;
    end else begin
      r_state <= w_state_n;
      r_arvalid <= w_arvalid_n;
      r_rready <= w_rready_n;
      r_idu_valid <= w_idu_valid_n;
      r_exu_ready <= w_exu_ready_n;
      r_err <= w_err_n;
      r_inst <= w_inst_n;
      r_pc <= w_pc_n;
    end
  end
endmodule

// File: tb/tb_ysyx_24080006_if_stage.sv
// tb_ysyx_24080006_if_stage: random-delay memory/decode/execute environment with a PC-sequence reference model
module tb_ysyx_24080006_if_stage;
  localparam logic [31:0] RPC = 32'h3000_0000;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] ifu_araddr;
  logic ifu_arvalid;
  logic ifu_arready = 1'b0;
  logic [2:0] ifu_arsize;
  logic [7:0] ifu_arlen;
  logic [1:0] ifu_arburst;
  logic [31:0] ifu_rdata = 32'd0;
  logic [1:0] ifu_rresp = 2'b00;
  logic ifu_rlast = 1'b1;
  logic ifu_rvalid = 1'b0;
  logic ifu_rready;
  logic ifu2idu_valid;
  logic idu2ifu_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic fetch_err;
  logic ifu2exu_ready;
  logic exu2ifu_valid = 1'b0;
  logic [31:0] exu2ifu_dnpc = 32'd0;
  logic exu2ifu_jump = 1'b0;
  logic exu2ifu_branch = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int n_ar = 0;
  logic [31:0] exp_pc;

  ysyx_24080006_if_stage dut (
    .clock(clock), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .ifu2idu_valid(ifu2idu_valid), .idu2ifu_ready(idu2ifu_ready),
    .inst(inst), .pc(pc), .fetch_err(fetch_err),
    .ifu2exu_ready(ifu2exu_ready), .exu2ifu_valid(exu2ifu_valid),
    .exu2ifu_dnpc(exu2ifu_dnpc), .exu2ifu_jump(exu2ifu_jump), .exu2ifu_branch(exu2ifu_branch)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (!reset && ifu_arvalid && ifu_arready) n_ar <= n_ar + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic fetch_one(input int ar_d, input int r_d, input int id_d, input int ex_d,
                           input logic [31:0] data, input logic [1:0] resp,
                           input logic jmp, input logic br, input logic [31:0] dnpc);
    int t;
    int ar0;
    logic [31:0] word;
    t = 0;
    word = {exp_pc[31:2], 2'b00};
    while (!ifu_arvalid && t < 20) begin step(); t++; end
    check("ar_wait", {31'd0, ifu_arvalid}, 32'd1);
    if (!ifu_arvalid) return;
    ar0 = n_ar;
    check("araddr", ifu_araddr, word);
    for (int i = 0; i < ar_d; i++) begin
      ifu_rvalid = 1'b1;
      ifu_rdata = $urandom;
      step();
      check("ar_hold_v", {31'd0, ifu_arvalid}, 32'd1);
      check("ar_hold_a", ifu_araddr, word);
    end
    ifu_rvalid = 1'b0;
    ifu_arready = 1'b1;
    step();
    ifu_arready = 1'b0;
    check("ar_done", {30'd0, ifu_arvalid, ifu_rready}, 32'd1);
    for (int i = 0; i < r_d; i++) begin
      step();
      check("r_wait", {30'd0, ifu2idu_valid, ifu_rready}, 32'd1);
    end
    ifu_rvalid = 1'b1;
    ifu_rdata = data;
    ifu_rresp = resp;
    step();
    ifu_rvalid = 1'b0;
    ifu_rdata = $urandom;
    ifu_rresp = 2'b00;
    check("idu_valid", {30'd0, ifu2idu_valid, ifu_rready}, 32'd2);
    check("inst", inst, data);
    check("pc", pc, exp_pc);
    check("fetch_err", {31'd0, fetch_err}, {31'd0, (resp != 2'b00) || (exp_pc[1:0] != 2'b00)});
    for (int i = 0; i < id_d; i++) begin
      exu2ifu_valid = 1'b1;
      exu2ifu_jump = 1'b1;
      exu2ifu_dnpc = $urandom;
      step();
      check("id_hold_v", {30'd0, ifu2idu_valid, ifu_arvalid}, 32'd2);
      check("id_hold_i", inst, data);
      check("id_hold_pc", pc, exp_pc);
    end
    exu2ifu_valid = 1'b0;
    exu2ifu_jump = 1'b0;
    idu2ifu_ready = 1'b1;
    step();
    idu2ifu_ready = 1'b0;
    check("id_done", {30'd0, ifu2idu_valid, ifu2exu_ready}, 32'd1);
    for (int i = 0; i < ex_d; i++) begin
      step();
      check("ex_wait", {30'd0, ifu2exu_ready, ifu_arvalid}, 32'd2);
      check("ex_wait_pc", pc, exp_pc);
    end
    exu2ifu_valid = 1'b1;
    exu2ifu_jump = jmp;
    exu2ifu_branch = br;
    exu2ifu_dnpc = dnpc;
    step();
    exu2ifu_valid = 1'b0;
    exu2ifu_jump = 1'b0;
    exu2ifu_branch = 1'b0;
    exp_pc = (jmp || br) ? dnpc : exp_pc + 32'd4;
    check("ex_done", {30'd0, ifu2exu_ready, ifu_arvalid}, 32'd1);
    check("next_pc", pc, exp_pc);
    check("one_ar", n_ar - ar0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0] rs;
    int mode;
    repeat (3) step();
    check("rst_arvalid", {31'd0, ifu_arvalid}, 32'd0);
    check("rst_handshakes", {29'd0, ifu_rready, ifu2idu_valid, ifu2exu_ready}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_pc", pc, RPC);
    check("ar_const", {19'd0, ifu_arsize, ifu_arlen, ifu_arburst}, {19'd0, 3'b010, 8'd0, 2'b01});
    reset = 1'b0;
    step();
    check("boot_arvalid", {31'd0, ifu_arvalid}, 32'd1);
    check("boot_araddr", ifu_araddr, RPC);
    exp_pc = RPC;
    fetch_one(0, 0, 0, 0, 32'h0000_0013, 2'b00, 1'b0, 1'b0, 32'h0);
    fetch_one(0, 0, 0, 0, 32'h1234_5678, 2'b00, 1'b0, 1'b1, 32'h3000_0100);
    fetch_one(0, 0, 0, 0, 32'h0badc0de, 2'b00, 1'b1, 1'b0, 32'h8000_0000);
    fetch_one(3, 5, 4, 2, 32'h00a0_0093, 2'b00, 1'b0, 1'b0, 32'h5555_5555);
    fetch_one(0, 0, 0, 0, 32'hdead_beef, 2'b10, 1'b1, 1'b0, 32'h3000_0102);
    fetch_one(0, 0, 0, 0, 32'h0000_0073, 2'b00, 1'b1, 1'b0, 32'hFFFF_FFFC);
    fetch_one(0, 1, 0, 0, 32'h0000_0013, 2'b00, 1'b0, 1'b0, 32'h0);
    fetch_one(1, 0, 1, 0, 32'h0000_0113, 2'b00, 1'b0, 1'b0, 32'h0);
    while (!ifu_arvalid) step();
    ifu_arready = 1'b1;
    step();
    ifu_arready = 1'b0;
    check("mid_r_rready", {31'd0, ifu_rready}, 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_ctl", {29'd0, ifu_arvalid, ifu_rready, ifu2idu_valid}, 32'd0);
    check("mid_rst_pc", pc, RPC);
    reset = 1'b0;
    ifu_rvalid = 1'b1;
    ifu_rdata = 32'hcafe_f00d;
    step();
    ifu_rvalid = 1'b0;
    check("late_r_ignored", {29'd0, ifu_arvalid, ifu_rready, ifu2idu_valid}, 32'd4);
    check("late_r_inst", inst, 32'd0);
    exp_pc = RPC;
    fetch_one(0, 0, 0, 0, 32'h0000_0513, 2'b00, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 40; k++) begin
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[1:0] = 2'b00;
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      mode = $urandom_range(0, 2);
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, rs, mode == 1, mode == 2, d);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
